// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared definitions for the GPR write-back arbiter: default widths and
// requester identifiers.
package gpr_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned NUM_GPR        = 2 ** ADDR_WIDTH_DEF;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// Bundle of write-back requests, decode hazard queries and register-file
// write port seen by the GPR write-back arbiter.
interface gpr_wb_arbiter_if
  import gpr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic                  alu_valid_i;
  logic                  alu_ready_o;
  logic [ADDR_WIDTH-1:0] alu_rd_i;
  logic [DATA_WIDTH-1:0] alu_dat_i;
  logic                  lsu_valid_i;
  logic                  lsu_ready_o;
  logic [ADDR_WIDTH-1:0] lsu_rd_i;
  logic [DATA_WIDTH-1:0] lsu_dat_i;
  logic                  issue_valid_i;
  logic [ADDR_WIDTH-1:0] issue_rd_i;
  logic [ADDR_WIDTH-1:0] rs1_i;
  logic [ADDR_WIDTH-1:0] rs2_i;
  logic                  rs1_busy_o;
  logic                  rs2_busy_o;
  logic                  rf_w_en_o;
  logic [ADDR_WIDTH-1:0] rf_rd_o;
  logic [DATA_WIDTH-1:0] rf_dat_o;

  modport master (
    output alu_valid_i, alu_rd_i, alu_dat_i,
    output lsu_valid_i, lsu_rd_i, lsu_dat_i,
    output issue_valid_i, issue_rd_i, rs1_i, rs2_i,
    input  alu_ready_o, lsu_ready_o, rs1_busy_o, rs2_busy_o,
    input  rf_w_en_o, rf_rd_o, rf_dat_o
  );

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_dat_i,
    input  lsu_valid_i, lsu_rd_i, lsu_dat_i,
    input  issue_valid_i, issue_rd_i, rs1_i, rs2_i,
    output alu_ready_o, lsu_ready_o, rs1_busy_o, rs2_busy_o,
    output rf_w_en_o, rf_rd_o, rf_dat_o
  );

endinterface

// File: rtl/gpr_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; req[0]/gnt[0] is the ALU, req[1]/gnt[1] the LSU.
// Only a true conflict moves the fairness pointer.
module rr_arb2
  import gpr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_e    last_grant_r;
  logic [1:0] gnt_s;

  // Grant selection from requests and fairness pointer
  always_comb begin
    gnt_s = 2'b00;
    case (req)
      2'b01:   gnt_s = 2'b01;
      2'b10:   gnt_s = 2'b10;
      2'b11:   gnt_s = (last_grant_r == REQ_LSU) ? 2'b01 : 2'b10;
      default: gnt_s = 2'b00;
    endcase
  end

  assign gnt = gnt_s;

  // Fairness pointer: LSU after reset so the ALU wins the first conflict
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= REQ_LSU;
    end else if (req == 2'b11) begin
      last_grant_r <= gnt_s[0] ? REQ_ALU : REQ_LSU;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Shares the single GPR write port between ALU and LSU write-back, registers
// the register-file write and tracks pending writes for decode RAW stalls.
module gpr_wb_arbiter
  import gpr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input logic             clk,
  input logic             rst,
  gpr_wb_arbiter_if.slave bus
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

  logic [1:0]            req_s;
  logic [1:0]            gnt_s;
  logic                  xfer_s;
  logic [ADDR_WIDTH-1:0] sel_rd_s;
  logic [DATA_WIDTH-1:0] sel_dat_s;
  logic                  rf_w_en_r;
  logic [ADDR_WIDTH-1:0] rf_rd_r;
  logic [DATA_WIDTH-1:0] rf_dat_r;
  logic [NUM_REGS-1:0]   sb_r;
  logic [NUM_REGS-1:0]   sb_set_s;
  logic [NUM_REGS-1:0]   sb_clr_s;
  logic [NUM_REGS-1:0]   sb_nxt_s;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_WIDTH-1:0] idx,
                                                 input logic en);
    logic [NUM_REGS-1:0] m;
    m      = {NUM_REGS{1'b0}};
    m[idx] = en;
    return m;
  endfunction

  // Requests are masked while in reset so nothing is accepted then
  assign req_s = rst ? 2'b00 : {bus.lsu_valid_i, bus.alu_valid_i};

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_s),
    .gnt (gnt_s)
  );

  assign bus.alu_ready_o = gnt_s[0];
  assign bus.lsu_ready_o = gnt_s[1];
  assign xfer_s          = gnt_s[0] | gnt_s[1];

  // Winning requester's destination and data
  always_comb begin
    if (gnt_s[1]) begin
      sel_rd_s  = bus.lsu_rd_i;
      sel_dat_s = bus.lsu_dat_i;
    end else begin
      sel_rd_s  = bus.alu_rd_i;
      sel_dat_s = bus.alu_dat_i;
    end
  end

  // Registered write port; x0 transfers complete but never enable the write
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_w_en_r <= 1'b0;
      rf_rd_r   <= {ADDR_WIDTH{1'b0}};
      rf_dat_r  <= {DATA_WIDTH{1'b0}};
    end else if (xfer_s) begin
      rf_w_en_r <= (sel_rd_s != {ADDR_WIDTH{1'b0}});
      rf_rd_r   <= sel_rd_s;
      rf_dat_r  <= sel_dat_s;
    end else begin
      rf_w_en_r <= 1'b0;
      rf_rd_r   <= rf_rd_r;
      rf_dat_r  <= rf_dat_r;
    end
  end

  assign bus.rf_w_en_o = rf_w_en_r;
  assign bus.rf_rd_o   = rf_rd_r;
  assign bus.rf_dat_o  = rf_dat_r;

  // Scoreboard next state: set applied after clear so a newer issue wins
  always_comb begin
    sb_set_s = onehot(bus.issue_rd_i, bus.issue_valid_i);
    sb_clr_s = onehot(rf_rd_r, rf_w_en_r);
    sb_nxt_s = (sb_r & ~sb_clr_s) | sb_set_s;
    sb_nxt_s[0] = 1'b0;
  end

  // Pending-write scoreboard register
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_r <= {NUM_REGS{1'b0}};
    end else begin
      sb_r <= sb_nxt_s;
    end
  end

  assign bus.rs1_busy_o = (bus.rs1_i != {ADDR_WIDTH{1'b0}}) && sb_r[bus.rs1_i];
  assign bus.rs2_busy_o = (bus.rs2_i != {ADDR_WIDTH{1'b0}}) && sb_r[bus.rs2_i];

endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
Shares the single GPR write port between two write-back requesters: the ALU and the LSU.
- Uses valid/ready handshakes with round-robin arbitration on conflict.
- Drives the register file's rd/dat/w_en through a registered output stage.
- Keeps a pending-write scoreboard per GPR so decode can stall on RAW hazards.
- Sits between the execute/memory stages and the register file; decode queries it.

Parameters:
ADDR_WIDTH, 5, GPR index width (2**ADDR_WIDTH registers)
DATA_WIDTH, 32, GPR data width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
alu_valid_i  in  1  ALU write-back request
alu_ready_o  out  1  ALU request granted this cycle
alu_rd_i  in  ADDR_WIDTH  ALU destination
alu_dat_i  in  DATA_WIDTH  ALU result
lsu_valid_i  in  1  LSU write-back request
lsu_ready_o  out  1  LSU request granted this cycle
lsu_rd_i  in  ADDR_WIDTH  LSU destination
lsu_dat_i  in  DATA_WIDTH  LSU load data
issue_valid_i  in  1  decode issued an instr that will write issue_rd_i
issue_rd_i  in  ADDR_WIDTH  destination of issued instr
rs1_i  in  ADDR_WIDTH  hazard query source 1
rs2_i  in  ADDR_WIDTH  hazard query source 2
rs1_busy_o  out  1  rs1_i has a pending write
rs2_busy_o  out  1  rs2_i has a pending write
rf_w_en_o  out  1  to register file write enable
rf_rd_o  out  ADDR_WIDTH  to register file write index
rf_dat_o  out  DATA_WIDTH  to register file write data

Behaviour:
- Reset (rst=1 at edge):
  - rf_w_en_o=0, rf_rd_o=0, rf_dat_o=0.
  - Scoreboard all 0.
  - last_grant=LSU, so the ALU wins the first conflict.
- Reset takes priority over all inputs, including mid-handshake. Requests pending during reset are not accepted.
- Ready outputs are combinational from the valid inputs and last_grant:
  - Only one valid: that requester gets ready=1.
  - Both valid: grant goes to the requester not in last_grant.
  - Neither valid: both ready=0.
- Handshake: a transfer occurs when valid&&ready. At most one transfer per cycle.
  - Requester must hold valid/rd/dat stable until ready.
  - A non-granted requester simply waits; no data is dropped.
- last_grant updates only on a transfer made while both requesters were valid (a true conflict). Uncontested grants leave it unchanged.
- Output stage:
  - A transfer in cycle N drives rf_w_en_o/rf_rd_o/rf_dat_o in cycle N+1. Latency is exactly 1.
  - No transfer: rf_w_en_o=0 next cycle. rf_rd_o/rf_dat_o hold their last values.
- x0 handling:
  - Transfer with rd=0 completes its handshake, but rf_w_en_o stays 0.
  - issue with rd=0 never sets scoreboard bit 0.
  - rs1_busy_o/rs2_busy_o for index 0 are always 0.
- Scoreboard:
  - bit[issue_rd_i] is set on issue_valid_i.
  - bit[rf_rd_o] is cleared on the cycle rf_w_en_o=1 (the register file commits at that edge).
  - Set and clear of the same index in the same cycle: set wins (a newer writer is pending).
  - Different indices in the same cycle: both apply.
- busy outputs are combinational reads of the current scoreboard. There is no bypass of an in-flight commit, so busy clears the cycle after rf_w_en_o.
- Write-back to an index that is not busy is legal; it clears nothing. A checker assertion flags it as a protocol warning.

Decomposition:
- Shared package gpr_pkg:
  - ADDR_WIDTH and DATA_WIDTH defaults.
  - Requester ID enum: REQ_ALU=0, REQ_LSU=1.
  - NUM_GPR = 2**ADDR_WIDTH.
- One natural sub-module: rr_arb2. It is a 2-way round-robin arbiter holding the last_grant register, with request inputs and one-hot grant outputs. Scoreboard and output stage stay inline.

Test Plan:
- Reset then idle -> rf_w_en_o=0, all busy=0, both ready=0.
- ALU only, rd=5, dat=0x1234 at cycle N -> alu_ready_o=1 at N; rf_w_en_o=1, rf_rd_o=5, rf_dat_o=0x1234 at N+1.
- Both valid for 3 consecutive cycles (ALU rd=1/2/3, LSU rd=9 held) -> grants ALU, LSU, ALU; rf_rd_o sequence 1, 9, 2.
- LSU write with rd=0, dat=0xFFFF -> lsu_ready_o=1, rf_w_en_o stays 0; issue rd=0 with rs1_i=0 -> rs1_busy_o=0.
- Issue rd=7 at N -> rs1_i=7 gives busy=1 from N+1. ALU write rd=7 committing at M while issue rd=7 at M -> bit stays 1. Next write to 7 -> busy=0 the cycle after its commit.
- Assert rst at a cycle where both requesters are valid and scoreboard bits 3 and 7 are set -> next cycle rf_w_en_o=0, all busy=0. The ALU wins the first grant after reset.
